// File: rtl/xpmwrap_pkg.sv
// Shared types and sizing helpers for the distributed-RAM read streamer.
package xpmwrap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n entries.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xpmwrap_sync_fifo.sv
// Register-based synchronous FIFO, first-word-fall-through; DEPTH must be a power of two.
module xpmwrap_sync_fifo
    import xpmwrap_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage is cleared so the head word reads 0 after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/xpmwrap_dpdistram_rd_streamer.sv
// Port-B read sequencer: turns (addr, len) commands into one read per cycle and
// re-times the RAM's fixed-latency data into a back-pressured valid/ready stream.
module xpmwrap_dpdistram_rd_streamer
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addrb_q;
    logic                  enb_q, last_q;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic                  done_q, done_d;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_last_q;
    logic [READ_LATENCY:0]   vld_chain, last_chain;

    logic                  issue, issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  credit_ok;
    logic [CW:0]           occ;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full;

    // The read issued this cycle (enb_q) is stage 0; the chain end lines up with ram_doutb.
    assign vld_chain  = {pipe_vld_q, enb_q};
    assign last_chain = {pipe_last_q, last_q};
    assign push       = vld_chain[READ_LATENCY];

    // Credit uses registered counts only; every issued-but-unpushed read is in inflight_q.
    assign occ       = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok = (occ < DEPTH_L) && !fifo_full;

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign ram_addrb  = addrb_q;
    assign ram_enb    = enb_q;
    assign ram_regceb = 1'b1;

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_dout[DATA_WIDTH-1:0];
    assign m_tlast  = !fifo_empty && fifo_dout[DATA_WIDTH];
    assign pop      = m_tvalid && m_tready;

    // Command FSM and read-issue decision.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = addr_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Pipeline and FIFO are empty here, so the first read needs no credit test.
                        issue      = 1'b1;
                        issue_addr = cmd_addr;
                        issue_last = (cmd_len == (ADDR_WIDTH + 1)'(1));
                        addr_d     = cmd_addr + 1'b1;
                        rem_d      = cmd_len - 1'b1;
                        state_d    = issue_last ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == (ADDR_WIDTH + 1)'(1));
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy of the latency pipeline.
    always_comb begin
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // FSM, counters, registered RAM controls and latency pipeline.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            addrb_q     <= '0;
            enb_q       <= 1'b0;
            last_q      <= 1'b0;
            inflight_q  <= '0;
            done_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            if (issue) addrb_q <= issue_addr;
            enb_q       <= issue;
            last_q      <= issue && issue_last;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
            pipe_vld_q  <= vld_chain[READ_LATENCY-1:0];
            pipe_last_q <= last_chain[READ_LATENCY-1:0];
        end
    end

    xpmwrap_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clka),
        .rst_i   (rsta),
        .push_i  (push),
        .din_i   ({last_chain[READ_LATENCY], ram_doutb}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
